// File: rtl/alu_issue.sv
// alu_issue: decode/issue register feeding the ALU (ports: clk/rst, in_* handshake + instr/operands, flush, out_* issued op, halted, issue_count)
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [15:0]      in_rs_data,
  input  logic [15:0]      in_rt_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op,
  output logic             out_sign,
  output logic [15:0]      out_a,
  output logic [15:0]      out_b,
  output logic             out_illegal,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count
);
  localparam logic [0:0] RUN = 1'b0, HALTED = 1'b1;
  logic [0:0] state;
  logic [4:0] opc, op;
  logic [1:0] fn;
  logic [15:0] a, b, imm5s, imm5z, imm8s, imm8z, imm11s;
  logic ill, accept, ack;
  assign opc = in_instr[15:11];
  assign fn = in_instr[1:0];
  assign imm5s = {{11{in_instr[4]}}, in_instr[4:0]};
  assign imm5z = {11'd0, in_instr[4:0]};
  assign imm8s = {{8{in_instr[7]}}, in_instr[7:0]};
  assign imm8z = {8'd0, in_instr[7:0]};
  assign imm11s = {{5{in_instr[10]}}, in_instr[10:0]};
  assign halted = state == HALTED;
  assign in_ready = !halted && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign ack = out_valid && out_ready;
  always_comb begin
    op = 5'd28;
    ill = 1'b0;
    a = '0;
    b = '0;
    casez (opc)
      5'b11011: begin op = {3'b000, fn}; a = in_rs_data; b = in_rt_data; end
      5'b11010: begin op = {3'b001, fn}; a = in_rs_data; b = in_rt_data; end
      5'b111??: begin op = {3'b011, opc[1:0]}; a = in_rs_data; b = in_rt_data; end
      // 01010/01011 (XORI/ANDNI style) take a zero-extended immediate
      5'b010??: begin op = {3'b000, opc[1:0]}; a = in_rs_data; b = opc[1] ? imm5z : imm5s; end
      5'b101??: begin op = {3'b001, opc[1:0]}; a = in_rs_data; b = imm5s; end
      5'b10000: begin op = 5'd8; a = in_rs_data; b = imm5s; end
      5'b10001: begin op = 5'd9; a = in_rs_data; b = imm5s; end
      5'b10011: begin op = 5'd10; a = in_rs_data; b = imm5s; end
      5'b11001: begin op = 5'd11; a = in_rs_data; end
      5'b01100: begin op = 5'd16; a = in_rs_data; b = imm8s; end
      5'b01101: begin op = 5'd17; a = in_rs_data; b = imm8s; end
      5'b01110: begin op = 5'd18; a = in_rs_data; b = imm8s; end
      5'b11000: begin op = 5'd19; b = imm8s; end
      5'b10010: begin op = 5'd20; a = in_rs_data; b = imm8z; end
      5'b00100: begin op = 5'd21; b = imm11s; end
      5'b00110: begin op = 5'd22; b = imm11s; end
      5'b00101: begin op = 5'd23; a = in_rs_data; b = imm8s; end
      5'b00111: begin op = 5'd24; a = in_rs_data; b = imm8s; end
      5'b00010: op = 5'd26;
      5'b00011: op = 5'd27;
      5'b00001: op = 5'd28;
      5'b00000: op = 5'd29;
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      out_valid <= 1'b0;
      out_op <= 5'd28;
      out_sign <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_illegal <= 1'b0;
      issue_count <= '0;
    end else begin
      // flush squashes both the held op and anything accepted this cycle
      if (flush) out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        out_op <= op;
        out_sign <= op != 5'd15;
        out_a <= a;
        out_b <= b;
        out_illegal <= ill;
        if (op == 5'd29) state <= HALTED;
      end else if (ack) out_valid <= 1'b0;
      if (ack && !(&issue_count)) issue_count <= issue_count + 1'b1;
    end
  end
endmodule
